// File: rtl/clock_ctrl_pkg.sv
// Shared types, constants and helpers for the clock_ctrl block.
package clock_pkg;

  localparam int TIME_W  = 6;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    EDIT_MIN = 3'd1,
    EDIT_SEC = 3'd2,
    EDIT_ALM = 3'd3,
    COMMIT   = 3'd4
  } clk_state_e;

  function automatic logic [TIME_W-1:0] inc_mod60(input logic [TIME_W-1:0] v);
    return (v >= TIME_W'(SEC_MAX)) ? '0 : v + TIME_W'(1);
  endfunction

  // Out-of-range live values are treated as 0 when captured for editing.
  function automatic logic [TIME_W-1:0] snap_time(input logic [TIME_W-1:0] v);
    return (v > TIME_W'(MIN_MAX)) ? '0 : v;
  endfunction

endpackage

// File: rtl/clock_ctrl_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
module tick_prescaler #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int                CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // clr has priority so a suppressed wrap never leaks a tick.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/clock_ctrl.sv
// Set-time sequencer for the min/sec counter: prescaled tick plus button-driven edit FSM.
// Optional alarm-minute editing and alarm pulse are enabled by CLOCK_CTRL_ALARM_EN.
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic [TIME_W-1:0] cur_min,
  input  logic [TIME_W-1:0] cur_sec,
  output logic              tick,
  output logic              ld_en,
  output logic [TIME_W-1:0] ld_min,
  output logic [TIME_W-1:0] ld_sec,
  output logic              editing,
`ifdef CLOCK_CTRL_ALARM_EN
  output logic              alarm,
`endif
  output logic [2:0]        state_o
);

  clk_state_e        state_q, state_d;
  logic [TIME_W-1:0] min_q, min_d;
  logic [TIME_W-1:0] sec_q, sec_d;
  logic              ld_en_q, ld_en_d;
  logic              presc_clr, presc_en;

`ifdef CLOCK_CTRL_ALARM_EN
  logic [TIME_W-1:0] alm_edit_q, alm_edit_d;
  logic [TIME_W-1:0] alm_q, alm_d;
  logic              alm_vld_q, alm_vld_d;
  logic              tick_dly_q, tick_dly_d;
`endif

  // A mode press in RUN clears the prescaler in the same edge, swallowing any due tick.
  assign presc_en  = (state_q == RUN);
  assign presc_clr = (state_q != RUN) || btn_mode;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (presc_clr),
    .en   (presc_en),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
`ifdef CLOCK_CTRL_ALARM_EN
    alm_edit_d = alm_edit_q;
    alm_d      = alm_q;
    alm_vld_d  = alm_vld_q;
    tick_dly_d = tick;
`endif
    case (state_q)
      RUN: begin
        if (btn_mode) begin
          state_d = EDIT_MIN;
          min_d   = snap_time(cur_min);
          sec_d   = snap_time(cur_sec);
        end
      end
      EDIT_MIN: begin
        if (btn_mode)     state_d = EDIT_SEC;
        else if (btn_inc) min_d   = inc_mod60(min_q);
      end
      EDIT_SEC: begin
`ifdef CLOCK_CTRL_ALARM_EN
        if (btn_mode)     state_d = EDIT_ALM;
`else
        if (btn_mode)     state_d = COMMIT;
`endif
        else if (btn_inc) sec_d   = inc_mod60(sec_q);
      end
`ifdef CLOCK_CTRL_ALARM_EN
      EDIT_ALM: begin
        if (btn_mode)     state_d    = COMMIT;
        else if (btn_inc) alm_edit_d = inc_mod60(alm_edit_q);
      end
`endif
      COMMIT: begin
        state_d = RUN;
`ifdef CLOCK_CTRL_ALARM_EN
        alm_d     = alm_edit_q;
        alm_vld_d = 1'b1;
`endif
      end
      default: state_d = RUN;
    endcase
    ld_en_d = (state_d == COMMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      min_q   <= '0;
      sec_q   <= '0;
      ld_en_q <= 1'b0;
`ifdef CLOCK_CTRL_ALARM_EN
      alm_edit_q <= '0;
      alm_q      <= '0;
      alm_vld_q  <= 1'b0;
      tick_dly_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      ld_en_q <= ld_en_d;
`ifdef CLOCK_CTRL_ALARM_EN
      alm_edit_q <= alm_edit_d;
      alm_q      <= alm_d;
      alm_vld_q  <= alm_vld_d;
      tick_dly_q <= tick_dly_d;
`endif
    end
  end

  assign ld_en   = ld_en_q;
  assign ld_min  = min_q;
  assign ld_sec  = sec_q;
  assign editing = (state_q != RUN);
  assign state_o = state_q;

`ifdef CLOCK_CTRL_ALARM_EN
  // The datapath has just advanced on the previous tick, so cur_* is the new time.
  assign alarm = tick_dly_q && (state_q == RUN) && alm_vld_q &&
                 (cur_sec == '0) && (cur_min == alm_q);
`endif

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl (TICK_DIV=4) against a cycle-level behavioural model.
module tb_clock_ctrl;

  localparam int TDIV  = 4;
  localparam int P_RUN = 0;
  localparam int P_MIN = 1;
  localparam int P_SEC = 2;
  localparam int P_ALM = 3;
  localparam int P_COM = 4;
`ifdef CLOCK_CTRL_ALARM_EN
  localparam int N_TO_COMMIT = 3;
`else
  localparam int N_TO_COMMIT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [5:0] cur_min = '0;
  logic [5:0] cur_sec = '0;
  logic       tick, ld_en, editing;
  logic [5:0] ld_min, ld_sec;
  logic [2:0] state_o;
`ifdef CLOCK_CTRL_ALARM_EN
  logic       alarm;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  int ph, emin, esec, ealm, alm, run_cnt;
  bit alm_vld, e_tick, prev_tick, e_ld;

  clock_ctrl #(.TICK_DIV(TDIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_mode(btn_mode),
    .btn_inc (btn_inc),
    .cur_min (cur_min),
    .cur_sec (cur_sec),
    .tick    (tick),
    .ld_en   (ld_en),
    .ld_min  (ld_min),
    .ld_sec  (ld_sec),
    .editing (editing),
`ifdef CLOCK_CTRL_ALARM_EN
    .alarm   (alarm),
`endif
    .state_o (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int snap(input int v);
    return (v > 59) ? 0 : v;
  endfunction

  task automatic model_reset();
    ph = P_RUN; emin = 0; esec = 0; ealm = 0; alm = 0; run_cnt = 0;
    alm_vld = 0; e_tick = 0; prev_tick = 0; e_ld = 0;
  endtask

  // One rising edge worth of behaviour, given the buttons sampled at that edge.
  task automatic model_edge(input bit m, input bit i);
    prev_tick = e_tick;
    e_tick = 0;
    case (ph)
      P_RUN: begin
        if (m) begin
          ph = P_MIN; emin = snap(int'(cur_min)); esec = snap(int'(cur_sec)); run_cnt = 0;
        end else begin
          run_cnt++;
          if (run_cnt % TDIV == 0) e_tick = 1;
        end
      end
      P_MIN: if (m) ph = P_SEC; else if (i) emin = (emin + 1) % 60;
`ifdef CLOCK_CTRL_ALARM_EN
      P_SEC: if (m) ph = P_ALM; else if (i) esec = (esec + 1) % 60;
      P_ALM: if (m) ph = P_COM; else if (i) ealm = (ealm + 1) % 60;
`else
      P_SEC: if (m) ph = P_COM; else if (i) esec = (esec + 1) % 60;
`endif
      default: begin
        ph = P_RUN; run_cnt = 0; alm = ealm; alm_vld = 1;
      end
    endcase
    e_ld = (ph == P_COM);
  endtask

  task automatic check_outputs();
    chk("tick", tick, e_tick);
    chk("ld_en", ld_en, e_ld);
    chk("editing", editing, ph != P_RUN);
    chk("state_o", state_o, ph);
    chk("ld_min", ld_min, emin);
    chk("ld_sec", ld_sec, esec);
`ifdef CLOCK_CTRL_ALARM_EN
    chk("alarm", alarm, prev_tick && ph == P_RUN && alm_vld &&
                        cur_sec == 0 && int'(cur_min) == alm);
`endif
  endtask

  task automatic cycle(input bit m, input bit i);
    btn_mode = m;
    btn_inc  = i;
    @(posedge clk);
    model_edge(m, i);
    #1;
    check_outputs();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  task automatic reset_dut();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    rst_n    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt, k;
    bit m, i;

    reset_dut();

    // Idle after reset: ticks at cycles 4, 8, 12
    cnt = 0;
    for (int n = 0; n < 12; n++) begin
      cycle(0, 0);
      cnt += int'(tick);
    end
    chk("idle_ticks", cnt, 3);

    // Full edit with seconds wrap 34+30 -> 4
    cur_min = 6'd12; cur_sec = 6'd34;
    cycle(1, 0);
    repeat (3) cycle(0, 1);
    cycle(1, 0);
    repeat (30) cycle(0, 1);
    repeat (N_TO_COMMIT - 1) cycle(1, 0);
    chk("commit_ld_en", ld_en, 1);
    chk("commit_min", ld_min, 15);
    chk("commit_sec", ld_sec, 4);
    cycle(0, 0);
    chk("ld_en_one_cycle", ld_en, 0);

    // No ticks while editing; first tick 5 edges after ld_en rises
    cnt = 0;
    cycle(1, 0);
    repeat (20) begin cycle(0, 0); cnt += int'(tick); end
    cycle(1, 0);
    repeat (20) begin cycle(0, 0); cnt += int'(tick); end
    repeat (N_TO_COMMIT - 1) cycle(1, 0);
    chk("edit_no_tick", cnt, 0);
    chk("commit2_ld_en", ld_en, 1);
    k = 0;
    do begin cycle(0, 0); k++; end while (!tick && k < 10);
    chk("commit_to_tick", k, 5);

    // Mode and inc together in EDIT_MIN: mode wins
    cur_min = 6'd10; cur_sec = 6'd20;
    cycle(1, 0);
    cycle(1, 1);
    chk("modeinc_state", state_o, P_SEC);
    chk("modeinc_min", ld_min, 10);
    repeat (N_TO_COMMIT - 1) cycle(1, 0);
    cycle(0, 0);

    // Mode press on a tick slot suppresses the tick; snapshot is pre-tick
    k = 0;
    while ((run_cnt % TDIV) != TDIV - 1 && k < 20) begin cycle(0, 0); k++; end
    cur_min = 6'd7; cur_sec = 6'd59;
    cycle(1, 0);
    chk("slot_tick_suppressed", tick, 0);
    chk("slot_snap_min", ld_min, 7);
    chk("slot_snap_sec", ld_sec, 59);

    // Async reset while in EDIT_SEC
    cycle(1, 0);
    chk("pre_reset_editing", editing, 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_state", state_o, P_RUN);
    chk("async_rst_editing", editing, 0);
    chk("async_rst_ld_en", ld_en, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cnt = 0;
    repeat (8) begin cycle(0, 0); cnt += int'(ld_en); end
    chk("no_ld_after_reset", cnt, 0);

    // Snapshot of out-of-range seconds
    cur_min = 6'd5; cur_sec = 6'd63;
    cycle(1, 0);
    chk("snap63_sec", ld_sec, 0);
    chk("snap63_min", ld_min, 5);
    repeat (N_TO_COMMIT) cycle(1, 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      cur_min = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 3));
      cur_sec = ($urandom_range(0, 1) == 1) ? 6'd0 : 6'($urandom_range(0, 63));
      m = ($urandom_range(0, 5) == 0);
      i = ($urandom_range(0, 2) == 0);
      cycle(m, i);
    end

`ifdef CLOCK_CTRL_ALARM_EN
    // Alarm: none while alm_vld=0, then one pulse per tick after arming minute 2
    reset_dut();
    cur_min = 6'd0; cur_sec = 6'd0;
    cnt = 0;
    repeat (10) begin cycle(0, 0); cnt += int'(alarm); end
    chk("alarm_not_armed", cnt, 0);
    cycle(1, 0);
    cycle(1, 0);
    cycle(1, 0);
    repeat (2) cycle(0, 1);
    cycle(1, 0);
    chk("alarm_commit", ld_en, 1);
    cur_min = 6'd2; cur_sec = 6'd0;
    cnt = 0;
    repeat (10) begin cycle(0, 0); cnt += int'(alarm); end
    chk("alarm_pulses", cnt, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
